// File: rtl/syn_filt_param.sv
// syn_filt_param: parametrised all-pole synthesis filter over one L-sample
// subframe on the shared scratch-memory bus. Filter memory is copied into a
// scratch area ahead of the new samples, so y[n-j] for n<j needs no special
// case, and y is written only after every sample has been computed.
module syn_filt_param #(
    parameter int L      = 40,
    parameter int M      = 10,
    parameter int SHIFT  = 3,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              update,
    input  logic [ADDR_W-1:0] xAddr,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [ADDR_W-1:0] yAddr,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [ADDR_W-1:0] tmpAddr,
    input  logic [31:0]       memIn,
    output logic [ADDR_W-1:0] memReadAddr,
    output logic [ADDR_W-1:0] memWriteAddr,
    output logic              memWriteEn,
    output logic [31:0]       memOut,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [3:0] {
        IDLE, LD_A, LD_B, SX, SA0, SMUL, TA, TY, TM, SR, CA, CB, UPD, UA, UB, DN
    } state_t;

    localparam logic [CNT_W-1:0]  L_C   = CNT_W'(L);
    localparam logic [CNT_W-1:0]  M_C   = CNT_W'(M);
    localparam logic [ADDR_W-1:0] M_A   = ADDR_W'(M);
    localparam logic [ADDR_W-1:0] LM_A  = ADDR_W'(L - M);
    localparam logic [31:0]       S_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0]       S_MIN = 32'h8000_0000;

    state_t            state;
    logic [CNT_W-1:0]  i_cnt, j_cnt, k_cnt;
    logic [31:0]       acc;
    logic [15:0]       x_reg, a_reg;
    logic              upd_reg;

    logic signed [15:0] prod_a, prod_b;
    logic signed [31:0] mult_raw;
    logic [31:0]        mult_val, msu_val, shl_val;
    logic [32:0]        diff, rnd_sum;
    logic [47:0]        shl_wide;
    logic [15:0]        rnd_val;
    logic               mult_sat, msu_sat, shl_sat, rnd_sat;
    logic [CNT_W-1:0]   k_next, i_next, j_next;

    assign k_next = k_cnt + CNT_W'(1);
    assign i_next = i_cnt + CNT_W'(1);
    assign j_next = j_cnt + CNT_W'(1);

    // Saturating Q15 basic ops: L_mult, L_msu, L_shl and round on the accumulator.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, otherwise a latch is inferred.
        prod_a   = (state == SMUL) ? x_reg : a_reg;
        prod_b   = memIn[15:0];
        mult_raw = prod_a * prod_b;
        // -1 * -1 is the only product whose doubling leaves the 32-bit range.
        mult_sat = (prod_a == 16'sh8000) && (prod_b == 16'sh8000);
        mult_val = mult_sat ? S_MAX : {mult_raw[30:0], 1'b0};

        diff     = {acc[31], acc} - {mult_val[31], mult_val};
        msu_sat  = diff[32] != diff[31];
        msu_val  = msu_sat ? (diff[32] ? S_MIN : S_MAX) : diff[31:0];

        shl_wide = {{16{acc[31]}}, acc} << SHIFT;
        shl_sat  = shl_wide[47:31] != {17{shl_wide[47]}};
        shl_val  = shl_sat ? (acc[31] ? S_MIN : S_MAX) : shl_wide[31:0];

        // Adding +0x8000 can only overflow upward, which clamps to 0x7FFF.
        rnd_sum  = {shl_val[31], shl_val} + 33'h0_0000_8000;
        rnd_sat  = rnd_sum[32] != rnd_sum[31];
        rnd_val  = rnd_sat ? 16'h7FFF : rnd_sum[31:16];
    end

    // Memory bus decode: each state drives at most one read and one write; idle states drive 0.
    always_comb begin
        memReadAddr  = '0;
        memWriteAddr = '0;
        memWriteEn   = 1'b0;
        memOut       = '0;
        case (state)
            LD_A: memReadAddr = memAddr + ADDR_W'(k_cnt);
            LD_B: begin
                memWriteAddr = tmpAddr + ADDR_W'(k_cnt);
                memWriteEn   = 1'b1;
                memOut       = {{16{memIn[15]}}, memIn[15:0]};
            end
            SX:   memReadAddr = xAddr + ADDR_W'(i_cnt);
            SA0:  memReadAddr = aAddr;
            TA:   memReadAddr = aAddr + ADDR_W'(j_cnt);
            TY:   memReadAddr = tmpAddr + M_A + ADDR_W'(i_cnt) - ADDR_W'(j_cnt);
            SR: begin
                memWriteAddr = tmpAddr + M_A + ADDR_W'(i_cnt);
                memWriteEn   = 1'b1;
                memOut       = {{16{rnd_val[15]}}, rnd_val};
            end
            CA:   memReadAddr = tmpAddr + M_A + ADDR_W'(k_cnt);
            CB: begin
                memWriteAddr = yAddr + ADDR_W'(k_cnt);
                memWriteEn   = 1'b1;
                memOut       = {{16{memIn[15]}}, memIn[15:0]};
            end
            UA:   memReadAddr = yAddr + LM_A + ADDR_W'(k_cnt);
            UB: begin
                memWriteAddr = memAddr + ADDR_W'(k_cnt);
                memWriteEn   = 1'b1;
                memOut       = {{16{memIn[15]}}, memIn[15:0]};
            end
            default: ;
        endcase
    end

    // Sequencer: copy memory in, filter each sample, copy y out, optionally refresh memory.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            acc      <= '0;
            x_reg    <= '0;
            a_reg    <= '0;
            upd_reg  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    overflow <= 1'b0;
                    upd_reg  <= update;
                    k_cnt    <= '0;
                    busy     <= 1'b1;
                    state    <= LD_A;
                end
                LD_A: state <= LD_B;
                LD_B: begin
                    k_cnt <= k_next;
                    if (k_next == M_C) begin
                        i_cnt <= '0;
                        state <= SX;
                    end else begin
                        state <= LD_A;
                    end
                end
                SX:   state <= SA0;
                SA0: begin
                    x_reg <= memIn[15:0];
                    state <= SMUL;
                end
                SMUL: begin
                    acc   <= mult_val;
                    j_cnt <= CNT_W'(1);
                    if (mult_sat) overflow <= 1'b1;
                    state <= TA;
                end
                TA:   state <= TY;
                TY: begin
                    a_reg <= memIn[15:0];
                    state <= TM;
                end
                TM: begin
                    acc   <= msu_val;
                    j_cnt <= j_next;
                    if (mult_sat || msu_sat) overflow <= 1'b1;
                    state <= (j_cnt == M_C) ? SR : TA;
                end
                SR: begin
                    if (shl_sat || rnd_sat) overflow <= 1'b1;
                    i_cnt <= i_next;
                    if (i_next == L_C) begin
                        k_cnt <= '0;
                        state <= CA;
                    end else begin
                        state <= SX;
                    end
                end
                CA:   state <= CB;
                CB: begin
                    k_cnt <= k_next;
                    if (k_next != L_C) begin
                        state <= CA;
                    end else if (upd_reg) begin
                        state <= UPD;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DN;
                    end
                end
                UPD: begin
                    k_cnt <= '0;
                    state <= UA;
                end
                UA:   state <= UB;
                UB: begin
                    k_cnt <= k_next;
                    if (k_next == M_C) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DN;
                    end else begin
                        state <= UA;
                    end
                end
                DN:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_filt_param.sv
// tb_syn_filt_param: directed vectors with hand-computed results. The driver
// queues the expected y/mem writes and completion record before each start;
// a monitor pops and compares whenever the DUT writes y/mem or pulses done.
// Latency is measured as the number of busy cycles ahead of the done pulse.
module tb_syn_filt_param;

    localparam int L  = 40;
    localparam int M  = 10;
    localparam int AW = 11;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        int   cycles;
        logic ovf;
    } done_t;

    logic          clk = 1'b0;
    logic          reset, start, update;
    logic [AW-1:0] xAddr, aAddr, yAddr, memAddr, tmpAddr;
    logic [31:0]   memIn;
    logic [AW-1:0] memReadAddr, memWriteAddr;
    logic          memWriteEn;
    logic [31:0]   memOut;
    logic          busy, done, overflow;

    logic [31:0]   ram [0:(1<<AW)-1];
    logic          tb_we;
    logic [AW-1:0] tb_waddr;
    logic [31:0]   tb_wdata;

    logic [15:0]   xv [L];
    logic [15:0]   av [M+1];
    logic [15:0]   mv [M];
    logic [15:0]   yv [L];

    wr_t           exp_wr[$];
    done_t         exp_done[$];
    logic [AW-1:0] cur_y, cur_mem;
    string         cur_tag;
    int            vectors     = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    syn_filt_param #(.L(L), .M(M), .SHIFT(3), .ADDR_W(AW), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .update       (update),
        .xAddr        (xAddr),
        .aAddr        (aAddr),
        .yAddr        (yAddr),
        .memAddr      (memAddr),
        .tmpAddr      (tmpAddr),
        .memIn        (memIn),
        .memReadAddr  (memReadAddr),
        .memWriteAddr (memWriteAddr),
        .memWriteEn   (memWriteEn),
        .memOut       (memOut),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    // Scratch memory: one-cycle read latency; the bench preloads through its own port while the DUT idles.
    always @(posedge clk) begin
        memIn <= ram[memReadAddr];
        if (memWriteEn)  ram[memWriteAddr] <= memOut;
        else if (tb_we)  ram[tb_waddr]     <= tb_wdata;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic in_rng(input logic [AW-1:0] a, input logic [AW-1:0] base, input int n);
        logic [AW-1:0] d;
        d = a - base;
        return int'(d) < n;
    endfunction

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Monitor: compares every y/mem write and every done pulse against the queued expectations.
    initial begin
        int   busy_cnt;
        wr_t  ew;
        done_t ed;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (memWriteEn && (in_rng(memWriteAddr, cur_y, L) || in_rng(memWriteAddr, cur_mem, M))) begin
                    if (exp_wr.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL %s_unexpected_write: got addr %h data %h, expected no write", cur_tag, memWriteAddr, memOut);
                    end else begin
                        ew = exp_wr.pop_front();
                        check({cur_tag, "_wr_addr"}, 32'(memWriteAddr), 32'(ew.addr));
                        check({cur_tag, "_wr_data"}, memOut, ew.data);
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL %s_unexpected_done: got done=1, expected none", cur_tag);
                    end else begin
                        ed = exp_done.pop_front();
                        check({cur_tag, "_latency"}, 32'(busy_cnt), 32'(ed.cycles));
                        check({cur_tag, "_overflow"}, 32'(overflow), 32'(ed.ovf));
                        check({cur_tag, "_busy_at_done"}, 32'(busy), 32'(0));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdata = sext(d);
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] xb, input logic [AW-1:0] ab, input logic [AW-1:0] mb);
        for (int n = 0; n < L; n++)  wr(xb + AW'(n), xv[n]);
        for (int n = 0; n <= M; n++) wr(ab + AW'(n), av[n]);
        for (int n = 0; n < M; n++)  wr(mb + AW'(n), mv[n]);
    endtask

    task automatic set_ports(input logic upd, input logic [AW-1:0] xb, input logic [AW-1:0] ab,
                             input logic [AW-1:0] yb, input logic [AW-1:0] mb, input logic [AW-1:0] tb);
        update  = upd;
        xAddr   = xb;
        aAddr   = ab;
        yAddr   = yb;
        memAddr = mb;
        tmpAddr = tb;
        cur_y   = yb;
        cur_mem = mb;
    endtask

    task automatic run_case(input string tag, input logic upd,
                            input logic [AW-1:0] xb, input logic [AW-1:0] ab, input logic [AW-1:0] yb,
                            input logic [AW-1:0] mb, input logic [AW-1:0] tb,
                            input logic poke, input int exp_cycles, input logic exp_ovf);
        wr_t   ew;
        done_t ed;
        int    n;
        load(xb, ab, mb);
        cur_tag = tag;
        set_ports(upd, xb, ab, yb, mb, tb);
        for (int q = 0; q < L; q++) begin
            ew.addr = yb + AW'(q);
            ew.data = sext(yv[q]);
            exp_wr.push_back(ew);
        end
        if (upd) begin
            for (int q = 0; q < M; q++) begin
                ew.addr = mb + AW'(q);
                ew.data = sext(yv[L-M+q]);
                exp_wr.push_back(ew);
            end
        end
        ed.cycles = exp_cycles;
        ed.ovf    = exp_ovf;
        exp_done.push_back(ed);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            start = poke && (n == 100);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no done within %0d cycles, expected done", tag, n);
        end
        @(negedge clk);
        check({tag, "_done_pulse_width"}, 32'(done), 32'(0));
        check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'(0));
        check({tag, "_done_left"}, 32'(exp_done.size()), 32'(0));
        exp_wr.delete();
        exp_done.delete();
    endtask

    task automatic clear_vectors();
        for (int n = 0; n < L; n++)  begin xv[n] = 16'h0; yv[n] = 16'h0; end
        for (int n = 0; n <= M; n++) av[n] = 16'h0;
        for (int n = 0; n < M; n++)  mv[n] = 16'h0;
    endtask

    task automatic impulse_vectors();
        clear_vectors();
        xv[0] = 16'h1000;
        av[0] = 16'h1000;
        yv[0] = 16'h1000;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},       32'(busy),         32'(0));
        check({tag, "_done"},       32'(done),         32'(0));
        check({tag, "_overflow"},   32'(overflow),     32'(0));
        check({tag, "_we"},         32'(memWriteEn),   32'(0));
        check({tag, "_read_addr"},  32'(memReadAddr),  32'(0));
        check({tag, "_write_addr"}, 32'(memWriteAddr), 32'(0));
        check({tag, "_mem_out"},    memOut,            32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        tb_we = 1'b0;
        tb_waddr = '0;
        tb_wdata = '0;
        cur_tag = "reset";
        set_ports(1'b0, '0, '0, 11'h300, 11'h400, '0);
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Impulse through a pure gain: 0x1000*0x1000*2 <<3, rounded, is 0x1000.
        impulse_vectors();
        run_case("impulse", 1'b1, 11'h100, 11'h200, 11'h300, 11'h400, 11'h500, 1'b0, 1481, 1'b0);

        // One pole at +0.5: y[n] = round-half-up(y[n-1]/2), so the tail settles at 1, not 0.
        impulse_vectors();
        av[1] = 16'hF800;
        for (int n = 0; n < L; n++) yv[n] = (n <= 12) ? (16'h1000 >> n) : 16'h0001;
        run_case("one_pole", 1'b1, 11'h100, 11'h200, 11'h300, 11'h400, 11'h500, 1'b0, 1481, 1'b0);

        // History only, pole at +1.0, output written in place over x.
        clear_vectors();
        av[0] = 16'h1000;
        av[1] = 16'hF000;
        mv[M-1] = 16'd1000;
        for (int n = 0; n < L; n++) yv[n] = 16'd1000;
        run_case("history", 1'b1, 11'h100, 11'h200, 11'h100, 11'h400, 11'h500, 1'b0, 1481, 1'b0);

        // Full-scale input: the shift saturates, round clamps to 0x7FFF, overflow sticks.
        clear_vectors();
        xv[0] = 16'h7FFF;
        av[0] = 16'h7FFF;
        yv[0] = 16'h7FFF;
        run_case("saturate", 1'b1, 11'h100, 11'h200, 11'h300, 11'h400, 11'h500, 1'b0, 1481, 1'b1);
        repeat (3) @(negedge clk);
        check("saturate_sticky", 32'(overflow), 32'(1));

        // Clean run without update: overflow clears, mem untouched, stray start ignored, scratch wraps.
        impulse_vectors();
        for (int n = 0; n < M; n++) mv[n] = 16'h0100 + 16'(n);
        run_case("no_update", 1'b0, 11'h100, 11'h200, 11'h300, 11'h400, 11'h7F8, 1'b1, 1460, 1'b0);
        for (int n = 0; n < M; n++) check("no_update_mem_kept", ram[11'h400 + AW'(n)], sext(mv[n]));

        // Abort in the first TM (26th busy cycle) after L_mult(0x8000,0x8000) saturated.
        clear_vectors();
        xv[0] = 16'h8000;
        av[0] = 16'h8000;
        load(11'h100, 11'h200, 11'h400);
        cur_tag = "abort";
        set_ports(1'b1, 11'h100, 11'h200, 11'h300, 11'h400, 11'h500);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_overflow_before", 32'(overflow), 32'(1));
        check("abort_busy_before",     32'(busy),     32'(1));
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        reset = 1'b0;
        @(negedge clk);

        impulse_vectors();
        run_case("post_reset", 1'b1, 11'h100, 11'h200, 11'h300, 11'h400, 11'h500, 1'b0, 1481, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
